mem_access_ctrl: RTL and testbench

// - Initiator side of the multicycle unified instruction/data memory port.
// - Accepts fetch requests (IF) and load/store requests (D) from the core control FSM.
// - Arbitrates between them, drives pc/dataaddr/iord/irwrite/we/writedata to memory, acks the core.
// - Registers returned instr/readdata, so core-side data is held stable until the next access.

---
 rtl/mem_access_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mem_access_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// Initiator side of the multicycle unified instruction/data memory port: arbitrates fetch vs load/store
// requests, drives the memory control/address lines and holds returned data. Optional macro: MEM_ADDR_CHECK_EN.
module mem_access_ctrl #(
    parameter int D_PRIORITY = 1,
    parameter int MEM_WORDS  = 128
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_pc,
    output logic        if_ack,
    output logic [31:0] if_instr,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        busy,
    output logic        fault,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_dataaddr,
    output logic [31:0] mem_writedata,
    output logic        mem_iord,
    output logic        mem_irwrite,
    output logic        mem_we,
    input  logic [31:0] mem_instr,
    input  logic [31:0] mem_readdata
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_IF_ISSUE = 3'd1;
    localparam logic [2:0] ST_IF_DONE  = 3'd2;
    localparam logic [2:0] ST_LD_ISSUE = 3'd3;
    localparam logic [2:0] ST_LD_DONE  = 3'd4;
    localparam logic [2:0] ST_ST_ISSUE = 3'd5;
    localparam logic [2:0] ST_ST_DONE  = 3'd6;

    logic [2:0]  state_q, state_d;
    logic        arb_en_s, if_pend_s, d_pend_s;
    logic        grant_if_s, grant_d_s;
    logic        issue_fault_s, in_issue_s;
    logic [31:0] pc_q, daddr_q, wdata_q;
    logic        iord_q, irwrite_q, we_q;
    logic        if_ack_q, d_ack_q, busy_q, acc_fault_q;
    logic [31:0] if_instr_q, d_rdata_q;

    // Arbitration; the port acked in a DONE cycle is masked so its still-high req is not re-issued
    always_comb begin
        arb_en_s  = 1'b0;
        if_pend_s = if_req;
        d_pend_s  = d_req;
        case (state_q)
            ST_IDLE: begin
                arb_en_s = 1'b1;
            end
            ST_IF_DONE: begin
                arb_en_s  = 1'b1;
                if_pend_s = 1'b0;
            end
            ST_LD_DONE, ST_ST_DONE: begin
                arb_en_s = 1'b1;
                d_pend_s = 1'b0;
            end
            default: begin
                arb_en_s = 1'b0;
            end
        endcase
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
        if (arb_en_s) begin
            if (if_pend_s && d_pend_s) begin
                grant_d_s  = (D_PRIORITY != 0);
                grant_if_s = (D_PRIORITY == 0);
            end else begin
                grant_d_s  = d_pend_s;
                grant_if_s = if_pend_s;
            end
        end else begin
            grant_if_s = 1'b0;
            grant_d_s  = 1'b0;
        end
    end

    // Next-state decode; unknown encodings fall back to IDLE through the default arm
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IF_ISSUE: state_d = ST_IF_DONE;
            ST_LD_ISSUE: state_d = ST_LD_DONE;
            ST_ST_ISSUE: state_d = ST_ST_DONE;
            default: begin
                if (grant_d_s) begin
                    state_d = d_we ? ST_ST_ISSUE : ST_LD_ISSUE;
                end else if (grant_if_s) begin
                    state_d = ST_IF_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign in_issue_s = (state_q == ST_IF_ISSUE) || (state_q == ST_LD_ISSUE) ||
                        (state_q == ST_ST_ISSUE);

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    function automatic logic addr_bad(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:2] >= WORD_LIMIT);
    endfunction

    assign issue_fault_s = grant_d_s ? addr_bad(d_addr) : addr_bad(if_pc);

    logic fault_q;

    // Fault pulse lines up with the ack of the faulting access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= in_issue_s && acc_fault_q;
        end
    end

    assign fault = fault_q;
`else
    assign issue_fault_s = 1'b0;
    assign fault         = 1'b0;
`endif

    // Main state and output registers; control outputs are decoded from the next state so they
    // align with the ISSUE/DONE cycles and clear asynchronously with reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            pc_q        <= 32'd0;
            daddr_q     <= 32'd0;
            wdata_q     <= 32'd0;
            iord_q      <= 1'b0;
            irwrite_q   <= 1'b0;
            we_q        <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            busy_q      <= 1'b0;
            acc_fault_q <= 1'b0;
            if_instr_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != ST_IDLE);
            if (grant_if_s) begin
                pc_q   <= if_pc;
                iord_q <= 1'b0;
            end else if (grant_d_s) begin
                daddr_q <= d_addr;
                wdata_q <= d_wdata;
                iord_q  <= 1'b1;
            end
            if (grant_if_s || grant_d_s) begin
                acc_fault_q <= issue_fault_s;
            end
            irwrite_q <= grant_if_s && !issue_fault_s;
            we_q      <= grant_d_s && d_we && !issue_fault_s;
            if_ack_q  <= (state_d == ST_IF_DONE);
            d_ack_q   <= (state_d == ST_LD_DONE) || (state_d == ST_ST_DONE);
            if ((state_q == ST_IF_DONE) && !acc_fault_q) begin
                if_instr_q <= mem_instr;
            end
            if ((state_q == ST_LD_DONE) && !acc_fault_q) begin
                d_rdata_q <= mem_readdata;
            end
        end
    end

    // Memory data registers are loaded by the issue cycle, so the DONE cycle forwards them directly
    assign if_instr = ((state_q == ST_IF_DONE) && !acc_fault_q) ? mem_instr : if_instr_q;
    assign d_rdata  = ((state_q == ST_LD_DONE) && !acc_fault_q) ? mem_readdata : d_rdata_q;

    assign if_ack        = if_ack_q;
    assign d_ack         = d_ack_q;
    assign busy          = busy_q;
    assign mem_pc        = pc_q;
    assign mem_dataaddr  = daddr_q;
    assign mem_writedata = wdata_q;
    assign mem_iord      = iord_q;
    assign mem_irwrite   = irwrite_q;
    assign mem_we        = we_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory attached to the port, reference memory image,
// directed scenarios followed by randomized fetch/load/store traffic.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        if_req, d_req, d_we;
    logic [31:0] if_pc, d_addr, d_wdata;
    logic        if_ack, d_ack, busy, fault;
    logic [31:0] if_instr, d_rdata;
    logic [31:0] mem_pc, mem_dataaddr, mem_writedata;
    logic        mem_iord, mem_irwrite, mem_we;
    logic [31:0] mem_instr, mem_readdata;

    int ncomp = 0;
    int nfail = 0;
    int ir_pulses = 0;
    int we_pulses = 0;
    time ack_t;
    logic ack_fault;

    logic [31:0] mem [0:127];
    logic [31:0] ref_mem [0:127];
    logic [31:0] ir_q, dr_q;
    logic        mem_ready = 1'b0;

    mem_access_ctrl #(.D_PRIORITY(1), .MEM_WORDS(128)) dut (
        .clk(clk), .resetn(resetn),
        .if_req(if_req), .if_pc(if_pc), .if_ack(if_ack), .if_instr(if_instr),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy), .fault(fault),
        .mem_pc(mem_pc), .mem_dataaddr(mem_dataaddr), .mem_writedata(mem_writedata),
        .mem_iord(mem_iord), .mem_irwrite(mem_irwrite), .mem_we(mem_we),
        .mem_instr(mem_instr), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'h2008_0005 : ((32'(i) * 32'h0001_0003) ^ 32'hA5A5_0000);
    endfunction

    // Multicycle memory: IR loads on irwrite, data register follows the data address every cycle
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_irwrite) ir_q <= mem[mem_pc[8:2]];
            if (mem_we) mem[mem_dataaddr[8:2]] <= mem_writedata;
            dr_q <= mem[mem_dataaddr[8:2]];
        end
    end
    assign mem_instr    = ir_q;
    assign mem_readdata = dr_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncomp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle invariants and strobe counters
    always @(negedge clk) begin
        if (mem_ready && resetn) begin
            check("irwrite_we_exclusive", 32'(mem_irwrite && mem_we), 32'd0);
`ifndef MEM_ADDR_CHECK_EN
            check("fault_tied_low", 32'(fault), 32'd0);
`endif
            if (mem_irwrite) ir_pulses++;
            if (mem_we) we_pulses++;
        end
    end

    // kind: 0 fetch, 1 load, 2 store. lat = cycles from request to ack, -1 on timeout.
    task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input bit keep, output int lat, output logic [31:0] data);
        logic got;
        @(posedge clk); #1;
        if (kind == 0) begin
            if_req = 1'b1; if_pc = addr;
        end else begin
            d_req = 1'b1; d_we = (kind == 2); d_addr = addr; d_wdata = wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = (kind == 0) ? if_ack : d_ack;
        end
        data      = (kind == 0) ? if_instr : d_rdata;
        ack_fault = fault;
        ack_t     = $time;
        if (!got) lat = -1;
        if (!keep) begin
            if (kind == 0) if_req = 1'b0;
            else d_req = 1'b0;
        end
    endtask

    initial begin
        int lat, kind, word, d_at, if_at, ir0, we0;
        logic [31:0] rd, wd, last_load, last_instr;
        time t0, t1;

        resetn = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_pc = 32'd0; d_addr = 32'd0; d_wdata = 32'd0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(|{if_ack, if_instr, d_ack, d_rdata, busy, fault, mem_pc,
              mem_dataaddr, mem_writedata, mem_iord, mem_irwrite, mem_we}), 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        access(0, 32'h10, 32'd0, 1'b0, lat, rd);
        check("fetch_latency", 32'(lat), 32'd2);
        check("fetch_instr", rd, 32'h2008_0005);
        last_instr = rd;

        access(2, 32'h20, 32'hDEAD_BEEF, 1'b0, lat, rd);
        ref_mem[8] = 32'hDEAD_BEEF;
        check("store_latency", 32'(lat), 32'd2);
        access(1, 32'h20, 32'd0, 1'b0, lat, rd);
        check("load_latency", 32'(lat), 32'd2);
        check("load_after_store", rd, 32'hDEAD_BEEF);
        last_load = rd;

        // Fetch and load raised together: data side first
        @(posedge clk); #1;
        if_req = 1'b1; if_pc = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        d_at = 0; if_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (d_ack) begin
                d_at = c; d_req = 1'b0;
                check("contend_d_rdata", d_rdata, ref_mem[8]);
            end
            if (if_ack) begin
                if_at = c; if_req = 1'b0;
                check("contend_if_instr", if_instr, ref_mem[4]);
            end
        end
        check("contend_d_ack_cycle", 32'(d_at), 32'd2);
        check("contend_if_ack_cycle", 32'(if_at), 32'd4);

        // Back-to-back fetches keeping if_req high across each ack
        ir0 = ir_pulses;
        access(0, 32'h0, 32'd0, 1'b1, lat, rd);
        check("b2b_f0", rd, ref_mem[0]);
        t0 = ack_t;
        access(0, 32'h4, 32'd0, 1'b1, lat, rd);
        check("b2b_f1", rd, ref_mem[1]);
        t1 = ack_t;
        check("b2b_gap1", 32'(t1 - t0), 32'd30);
        access(0, 32'h8, 32'd0, 1'b0, lat, rd);
        check("b2b_f2", rd, ref_mem[2]);
        check("b2b_gap2", 32'(ack_t - t1), 32'd30);
        last_instr = rd;
        repeat (4) @(posedge clk);
        check("b2b_no_duplicate", 32'(ir_pulses - ir0), 32'd3);

        // Reset asserted in the middle of a store issue cycle
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("store_issue_we", 32'(mem_we), 32'd1);
        resetn = 1'b0;
        #1;
        check("reset_drops_we", 32'(mem_we), 32'd0);
        check("reset_all_zero", 32'(|{if_ack, if_instr, d_ack, d_rdata, busy, fault, mem_pc,
              mem_dataaddr, mem_writedata, mem_iord, mem_irwrite, mem_we}), 32'd0);
        d_req = 1'b0;
        @(posedge clk); #1 resetn = 1'b1;
        check("reset_store_dropped", mem[16], ref_mem[16]);
        last_load = 32'd0;
        last_instr = 32'd0;

`ifdef MEM_ADDR_CHECK_EN
        access(1, 32'h22, 32'd0, 1'b0, lat, rd);
        check("misaligned_latency", 32'(lat), 32'd2);
        check("misaligned_fault", 32'(ack_fault), 32'd1);
        check("misaligned_rdata_held", rd, last_load);
        we0 = we_pulses;
        access(2, 32'h200, 32'h1234_5678, 1'b0, lat, rd);
        check("range_latency", 32'(lat), 32'd2);
        check("range_fault", 32'(ack_fault), 32'd1);
        check("range_no_we", 32'(we_pulses - we0), 32'd0);
`endif

        for (int n = 0; n < 30; n++) begin
            kind = int'($urandom_range(0, 2));
            word = int'($urandom_range(0, 127));
            wd   = $urandom;
            we0  = we_pulses;
            access(kind, 32'(word) << 2, wd, 1'b0, lat, rd);
            check("rand_latency", 32'(lat), 32'd2);
            check("rand_no_fault", 32'(ack_fault), 32'd0);
            if (kind == 0) begin
                check("rand_fetch", rd, ref_mem[word]);
                check("rand_rdata_held", d_rdata, last_load);
                last_instr = rd;
            end else if (kind == 1) begin
                check("rand_load", rd, ref_mem[word]);
                check("rand_instr_held", if_instr, last_instr);
                last_load = rd;
            end else begin
                ref_mem[word] = wd;
                check("rand_store_rdata_held", rd, last_load);
                check("rand_store_one_we", 32'(we_pulses - we0), 32'd1);
            end
        end

        repeat (2) @(posedge clk);
        for (int i = 0; i < 128; i++) check("final_mem", mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
        $finish;
    end

endmodule
